// File: rtl/softusb_crcgen.sv
`timescale 1ns/1ps
// softusb_crcgen: bit-serial CRC engine. ACCUM folds received bits into the register;
// EMIT shifts out the complemented CRC MSB-first while folding each emitted bit back in.
module softusb_crcgen #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = 16'h8005,
    parameter logic [WIDTH-1:0] INIT    = '1,
    parameter logic [WIDTH-1:0] RESIDUE = 16'h800D,
    parameter int unsigned      CNTW    = 11
) (
    input  logic             usb_clk,
    input  logic             usb_rst,
    input  logic             crc_reset,
    input  logic             data,
    input  logic             crc_ce,
    input  logic             crc_emit,
    output logic [WIDTH-1:0] crc,
    output logic             crc_valid,
    output logic             tx_data,
    output logic             tx_valid,
    output logic             tx_last,
    output logic [CNTW-1:0]  bit_count
);

    localparam int unsigned ECW = $clog2(WIDTH);

    typedef enum logic {
        StAccum,
        StEmit
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_crc;
    logic [WIDTH-1:0] w_crc_d;
    logic [WIDTH-1:0] w_crc_acc;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_d;
    logic [ECW-1:0]   r_emit_cnt;
    logic [ECW-1:0]   w_emit_cnt_d;
    logic [CNTW-1:0]  r_bit_count;
    logic [CNTW-1:0]  w_bit_count_d;
    logic             w_last;

    function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] c, input logic d);
        logic fb;
        fb = d ^ c[WIDTH-1];
        return {c[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    assign w_last = (r_emit_cnt == ECW'(WIDTH - 1));

    always_comb begin
        w_state_d     = r_state;
        w_crc_d       = r_crc;
        w_crc_acc     = r_crc;
        w_sh_d        = r_sh;
        w_emit_cnt_d  = r_emit_cnt;
        w_bit_count_d = r_bit_count;

        if (crc_reset) begin
            w_state_d     = StAccum;
            w_crc_d       = INIT;
            w_sh_d        = '0;
            w_emit_cnt_d  = '0;
            w_bit_count_d = '0;
        end else begin
            unique case (r_state)
                StAccum: begin
                    if (crc_ce) begin
                        w_crc_acc = f_next(r_crc, data);
                        w_crc_d   = w_crc_acc;
                        if (r_bit_count != '1) begin
                            w_bit_count_d = r_bit_count + CNTW'(1);
                        end
                    end
                    // A same-cycle data bit is covered by the emitted CRC.
                    if (crc_emit) begin
                        w_sh_d       = ~w_crc_acc;
                        w_emit_cnt_d = '0;
                        w_state_d    = StEmit;
                    end
                end
                StEmit: begin
                    if (crc_ce) begin
                        w_crc_d = f_next(r_crc, r_sh[WIDTH-1]);
                        w_sh_d  = {r_sh[WIDTH-2:0], 1'b0};
                        if (w_last) begin
                            w_emit_cnt_d = '0;
                            w_state_d    = StAccum;
                        end else begin
                            w_emit_cnt_d = r_emit_cnt + ECW'(1);
                        end
                    end
                end
                default: w_state_d = StAccum;
            endcase
        end
    end

    always_ff @(posedge usb_clk or posedge usb_rst) begin
        if (usb_rst) begin
            r_state     <= StAccum;
            r_crc       <= INIT;
            r_sh        <= '0;
            r_emit_cnt  <= '0;
            r_bit_count <= '0;
        end else begin
            r_state     <= w_state_d;
            r_crc       <= w_crc_d;
            r_sh        <= w_sh_d;
            r_emit_cnt  <= w_emit_cnt_d;
            r_bit_count <= w_bit_count_d;
        end
    end

    assign crc       = r_crc;
    assign crc_valid = (r_crc == RESIDUE);
    assign tx_valid  = (r_state == StEmit);
    assign tx_data   = tx_valid & r_sh[WIDTH-1];
    assign tx_last   = tx_valid & w_last;
    assign bit_count = r_bit_count;

endmodule

// File: doc/softusb_crcgen.md
# softusb_crcgen

Parametrised bit-serial CRC engine for the softusb datapath, superseding the fixed CRC5/CRC16 pair. It accumulates a CRC over an incoming NRZI-decoded, bit-unstuffed bit stream and flags a correct residue on receive. On transmit it serialises the complemented CRC MSB-first onto the outgoing bit stream, folding each emitted bit back into the register. One instance per CRC width; token paths use WIDTH=5, data paths use WIDTH=16.

## Interface
Parameters:
- WIDTH, 16, CRC register width (2..32)
- POLY, 16'h8005, generator polynomial without the x^WIDTH term; the CRC5 instance uses 5'h05
- INIT, all ones, register value after reset or crc_reset
- RESIDUE, 16'h800D, register value indicating a good packet; the CRC5 instance uses 5'h0C
- CNTW, 11, width of the bit counter

Ports:
- usb_clk  in  1  clock; everything is clocked on the rising edge
- usb_rst  in  1  asynchronous, active-high reset
- crc_reset  in  1  synchronous restart: register := INIT, state := ACCUM, bit_count := 0
- data  in  1  serial input bit, sampled when crc_ce=1 in ACCUM
- crc_ce  in  1  bit strobe, one bit per asserted cycle
- crc_emit  in  1  request to emit the complemented CRC; honoured only in ACCUM
- crc  out  WIDTH  current CRC register
- crc_valid  out  1  combinational (crc == RESIDUE)
- tx_data  out  1  current emitted bit
- tx_valid  out  1  high throughout EMIT
- tx_last  out  1  high while the final emitted bit is presented
- bit_count  out  CNTW  bits accepted in ACCUM since the last restart; saturates at all-ones

## Operation
- States: ACCUM and EMIT.
- Update function next(c, d):
  - fb = d ^ c[WIDTH-1]
  - result = (c << 1), truncated to WIDTH, XOR (fb ? POLY : 0)
- ACCUM, crc_ce=1:
  - crc <= next(crc, data)
  - bit_count increments, saturating
- ACCUM, crc_emit=1:
  - shift register sh <= ~crc_n, where crc_n is the register value after any same-cycle crc_ce update
  - emit counter <= 0
  - state <= EMIT
- EMIT:
  - tx_data = sh[WIDTH-1]
  - On crc_ce: crc <= next(crc, tx_data); sh shifts left; emit counter increments.
  - data and crc_emit are ignored.
- EMIT exit: after the WIDTH-th crc_ce in EMIT, state returns to ACCUM.
  - The register then equals RESIDUE by construction, so crc_valid=1; this serves as a transmit self-check.
- Priority, highest first: usb_rst, crc_reset, state-specific action.
- crc_reset during EMIT aborts emission immediately.

## Timing
- Reset values (usb_rst or crc_reset):
  - crc=INIT
  - state=ACCUM
  - tx_valid=0, tx_last=0, tx_data=0
  - bit_count=0
  - crc_valid reflects INIT==RESIDUE (0 for the standard instances)
- crc and bit_count change one cycle after the crc_ce edge; crc_valid follows crc in the same cycle.
- tx_valid and tx_data are valid in the cycle after crc_emit is accepted.
  - The first bit may be consumed by crc_ce in that cycle.
- tx_last=1 when the emit counter equals WIDTH-1.
- tx_valid drops in the cycle after the final crc_ce.
- Without crc_ce, EMIT holds indefinitely with outputs stable.
- crc_emit with crc_ce in the same ACCUM cycle: the data bit is included in the emitted CRC.
- crc_emit held high across EMIT has no effect; a new emit requires ACCUM.
- bit_count holds at all-ones once saturated and does not wrap.
- bit_count does not advance in EMIT.

## Test plan
- WIDTH=16 defaults: after reset, one crc_ce with data=0 -> crc=16'h7FFB; after crc_reset, one crc_ce with data=1 -> crc=16'hFFFE, bit_count=1.
- WIDTH=5 (POLY=5'h05, INIT=5'h1F, RESIDUE=5'h0C): data=1 -> crc=5'h1E; after restart, data=0 -> crc=5'h1B.
- WIDTH=16, zero-length packet: crc_emit right after reset, then crc_ce held high:
  - 16 tx_data bits all 0
  - tx_last on the 16th bit
  - then tx_valid=0, crc=16'h800D, crc_valid=1
- Random 8..64-bit payloads fed in ACCUM, then emitted; the emitted bits are fed into a second instance after the same payload -> second instance crc_valid=1. Flipping any one bit -> crc_valid=0.
- Boundary and abort cases:
  - crc_emit in the same cycle as crc_ce -> emitted CRC covers that bit.
  - crc_reset mid-EMIT -> next cycle tx_valid=0, crc=INIT.
  - usb_rst asserted between clock edges -> outputs clear without waiting for a clock edge.
- CNTW=3: feed 10 bits -> bit_count saturates at 7; crc_emit followed by 16 crc_ce -> bit_count stays 7.
